// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path.
// Holds the controller state encoding, the supported opcodes and the datapath
// mux select codes, so the controller and the datapath agree on one definition.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRExec   = 4'd6,
    StRWb     = 4'd7,
    StBranch  = 4'd8,
    StIExec   = 4'd9,
    StIWb     = 4'd10,
    StJump    = 4'd11,
    StJal     = 4'd12
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  // Register destination select
  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  // Write-back data select
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // ALU B operand select
  localparam logic [2:0] ALUB_B       = 3'b000;
  localparam logic [2:0] ALUB_FOUR    = 3'b001;
  localparam logic [2:0] ALUB_SEXT    = 3'b010;
  localparam logic [2:0] ALUB_SEXT_SH = 3'b011;
  localparam logic [2:0] ALUB_ZEXT    = 3'b100;

  // ALU operation select
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic op_is_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
      OP_ADDI, OP_ORI, OP_J, OP_JAL: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Ports:
//   clk, rst (sync, active high)  - clock and reset
//   op                            - IR[31:26], valid from DECODE onward
//   mem_ready                     - memory completes the current access
//   pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write,
//   reg_write                     - datapath enables / qualifiers
//   reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src
//                                 - datapath mux selects
//   illegal_op, instr_done, state - status and debug
module multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [2:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal_op,
  output logic       instr_done,
  output logic [3:0] state
);

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= StFetch;
    else     state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:   if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (op)
          OP_RTYPE:      state_d = StRExec;
          OP_LW, OP_SW:  state_d = StMemAddr;
          OP_BEQ, OP_BNE: state_d = StBranch;
          OP_ADDI, OP_ORI: state_d = StIExec;
          OP_J:          state_d = StJump;
          OP_JAL:        state_d = StJal;
          default:       state_d = StFetch;
        endcase
      end
      StMemAddr: state_d = (op == OP_LW) ? StMemRd : StMemWr;
      StMemRd:   if (mem_ready) state_d = StMemWb;
      StMemWr:   if (mem_ready) state_d = StFetch;
      StRExec:   state_d = StRWb;
      StIExec:   state_d = StIWb;
      StMemWb, StRWb, StBranch, StIWb, StJump, StJal: state_d = StFetch;
      default:   state_d = StFetch;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = REG_DST_RT;
    mem_to_reg    = M2R_ALUOUT;
    alu_src_a     = 1'b0;
    alu_src_b     = ALUB_B;
    alu_op        = ALUOP_ADD;
    pc_src        = PCSRC_ALU;
    illegal_op    = 1'b0;
    instr_done    = 1'b0;
    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = ALUB_FOUR;
        // PC+4 and IR load only on the cycle the fetch actually completes
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      StDecode: begin
        alu_src_b  = ALUB_SEXT_SH;
        illegal_op = ~op_is_legal(op);
        instr_done = ~op_is_legal(op);
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_SEXT;
      end
      StMemRd: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      StMemWb: begin
        mem_to_reg = M2R_MDR;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      StMemWr: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      StRExec: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      StRWb: begin
        reg_dst    = REG_DST_RD;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_src        = PCSRC_ALUOUT;
        pc_write_cond = 1'b1;
        branch_ne     = (op == OP_BNE);
        instr_done    = 1'b1;
      end
      StIExec: begin
        alu_src_a = 1'b1;
        if (op == OP_ADDI) begin
          alu_src_b = ALUB_SEXT;
          alu_op    = ALUOP_ADD;
        end else if (op == OP_ORI) begin
          alu_src_b = ALUB_ZEXT;
          alu_op    = ALUOP_OR;
        end
      end
      StIWb: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      StJump: begin
        pc_src     = PCSRC_JUMP;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      StJal: begin
        // Register file latches the already-incremented PC on this same edge
        pc_src     = PCSRC_JUMP;
        pc_write   = 1'b1;
        reg_dst    = REG_DST_RA;
        mem_to_reg = M2R_PC;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    // Reset squashes every side effect, whatever state is being abandoned
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, bne, iord, mrd, mwr, irw, rgw;
    logic [1:0] rdst, m2r;
    logic       asa;
    logic [2:0] asb;
    logic [1:0] aop, psrc;
    logic       ill, done;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = 6'h00;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
  logic       ir_write, reg_write, alu_src_a, illegal_op, instr_done;
  logic [1:0] reg_dst, mem_to_reg, alu_op, pc_src;
  logic [2:0] alu_src_b;
  logic [3:0] state;

  multicycle_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .op            (op),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .branch_ne     (branch_ne),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_src        (pc_src),
    .illegal_op    (illegal_op),
    .instr_done    (instr_done),
    .state         (state)
  );

  always #5 clk = ~clk;

  obs_t dut_obs;
  assign dut_obs = {state, pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write,
                    ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                    pc_src, illegal_op, instr_done};

  int n_checks = 0;
  int n_err = 0;

  // Planned trace: expected observation plus the stimulus for that cycle
  obs_t       exp_q[$];
  logic       mr_q[$];
  logic [5:0] op_q[$];

  obs_t       cur_exp;
  bit         chk_en = 1'b0;
  int         cur_pos = 0;
  int         done_cnt = 0;
  int         done_pos = 0;
  logic [3:0] st_log[$];

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (dut_obs !== cur_exp) begin
        n_err++;
        $display("FAIL cycle_obs pos=%0d: got %h, expected %h", cur_pos, dut_obs, cur_exp);
      end
      st_log.push_back(state);
      if (instr_done === 1'b1) begin
        done_cnt++;
        done_pos = cur_pos;
      end
    end
  end

  function automatic bit is_legal(input logic [5:0] o);
    return o inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h02, 6'h03};
  endfunction

  task automatic add(input obs_t o, input logic mr, input logic [5:0] opv);
    exp_q.push_back(o);
    mr_q.push_back(mr);
    op_q.push_back(opv);
  endtask

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  // Expected cycle-by-cycle trace of one instruction from the spec's state table
  task automatic build(input logic [5:0] o, input int wf, input int wm);
    obs_t e;
    for (int i = 0; i < wf; i++) begin
      e = '0; e.st = 4'd0; e.mrd = 1; e.asb = 3'b001;
      add(e, 1'b0, 6'($urandom));
    end
    e = '0; e.st = 4'd0; e.mrd = 1; e.asb = 3'b001; e.pcw = 1; e.irw = 1;
    add(e, 1'b1, 6'($urandom));
    e = '0; e.st = 4'd1; e.asb = 3'b011;
    if (!is_legal(o)) begin e.ill = 1; e.done = 1; end
    add(e, rbit(), o);
    case (o)
      6'h00: begin
        e = '0; e.st = 4'd6; e.asa = 1; e.aop = 2'b10; add(e, rbit(), o);
        e = '0; e.st = 4'd7; e.rdst = 2'b01; e.rgw = 1; e.done = 1; add(e, rbit(), o);
      end
      6'h23, 6'h2B: begin
        e = '0; e.st = 4'd2; e.asa = 1; e.asb = 3'b010; add(e, rbit(), o);
        e = '0; e.iord = 1;
        if (o == 6'h23) begin e.st = 4'd3; e.mrd = 1; end
        else begin e.st = 4'd5; e.mwr = 1; end
        for (int i = 0; i < wm; i++) add(e, 1'b0, o);
        if (o == 6'h2B) e.done = 1;
        add(e, 1'b1, o);
        if (o == 6'h23) begin
          e = '0; e.st = 4'd4; e.m2r = 2'b01; e.rgw = 1; e.done = 1; add(e, rbit(), o);
        end
      end
      6'h04, 6'h05: begin
        e = '0; e.st = 4'd8; e.asa = 1; e.aop = 2'b01; e.psrc = 2'b01; e.pcwc = 1;
        e.bne = (o == 6'h05); e.done = 1; add(e, rbit(), o);
      end
      6'h08, 6'h0D: begin
        e = '0; e.st = 4'd9; e.asa = 1;
        e.asb = (o == 6'h08) ? 3'b010 : 3'b100;
        e.aop = (o == 6'h08) ? 2'b00 : 2'b11;
        add(e, rbit(), o);
        e = '0; e.st = 4'd10; e.rgw = 1; e.done = 1; add(e, rbit(), o);
      end
      6'h02: begin
        e = '0; e.st = 4'd11; e.psrc = 2'b10; e.pcw = 1; e.done = 1; add(e, rbit(), o);
      end
      6'h03: begin
        e = '0; e.st = 4'd12; e.psrc = 2'b10; e.pcw = 1; e.rdst = 2'b10; e.m2r = 2'b10;
        e.rgw = 1; e.done = 1; add(e, rbit(), o);
      end
      default: ;
    endcase
  endtask

  task automatic run_q();
    int pos = 0;
    while (exp_q.size() > 0) begin
      cur_exp   = exp_q.pop_front();
      mem_ready = mr_q.pop_front();
      op        = op_q.pop_front();
      pos++;
      cur_pos = pos;
      chk_en  = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    chk_en = 1'b0;
  endtask

  task automatic do_instr(input logic [5:0] o, input int wf, input int wm, output int len);
    int d0;
    d0 = done_cnt;
    st_log.delete();
    build(o, wf, wm);
    len = exp_q.size();
    run_q();
    check(done_cnt - d0 == 1, "instr_done_once", done_cnt - d0, 1);
  endtask

  logic [5:0] ops[10]  = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h02, 6'h03, 6'h3F};
  int         lens[10] = '{4, 5, 4, 3, 3, 4, 4, 3, 3, 2};
  logic [3:0] lw_seq[7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
  logic [3:0] r_seq[4]  = '{4'd0, 4'd1, 4'd6, 4'd7};

  initial begin
    int len;
    logic [5:0] o;

    // Reset: state goes to FETCH on the first edge, enables held low
    rst = 1'b1; mem_ready = 1'b1; op = 6'h00;
    @(posedge clk); #1;
    @(negedge clk);
    check(state == 4'd0, "reset_state", state, 0);
    check({pc_write, ir_write, mem_read, mem_write, reg_write, pc_write_cond} == 6'b0,
          "reset_enables", {pc_write, ir_write, mem_read, mem_write, reg_write}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Zero-wait pass over every opcode; lengths pinned to literal cycle counts
    for (int i = 0; i < 10; i++) begin
      do_instr(ops[i], 0, 0, len);
      check(len == lens[i], "model_len", len, lens[i]);
      check(done_pos == lens[i], "done_cycle", done_pos, lens[i]);
      if (i == 0)
        for (int k = 0; k < 4; k++) check(st_log[k] == r_seq[k], "rtype_states", st_log[k], r_seq[k]);
    end

    // lw with two wait cycles in MEM_RD
    do_instr(6'h23, 0, 2, len);
    check(st_log.size() == 7, "lw_wait_len", st_log.size(), 7);
    for (int k = 0; k < 7 && k < st_log.size(); k++)
      check(st_log[k] == lw_seq[k], "lw_wait_states", st_log[k], lw_seq[k]);

    // Random instruction mix with random memory latency
    for (int n = 0; n < 200; n++) begin
      o = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 9) == 0) begin
        o = 6'($urandom);
        while (is_legal(o)) o = 6'($urandom);
      end
      do_instr(o, $urandom_range(0, 3), $urandom_range(0, 3), len);
    end

    // Reset held for three cycles while sitting in MEM_WR with mem_ready high
    op = 6'h2B; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    @(negedge clk);
    check(state == 4'd5 && mem_write == 1'b1, "in_mem_wr", {state, mem_write}, {4'd5, 1'b1});
    @(posedge clk); #1;
    rst = 1'b1; mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check(mem_write == 1'b0, "rst_no_mem_write", mem_write, 0);
      check({pc_write, pc_write_cond, ir_write, reg_write, mem_read} == 5'b0, "rst_no_enables",
            {pc_write, pc_write_cond, ir_write, reg_write, mem_read}, 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check(state == 4'd0, "post_rst_state", state, 0);
    check(mem_read == 1'b1 && pc_write == 1'b0 && ir_write == 1'b0, "post_rst_fetch_gated",
          {mem_read, pc_write, ir_write}, 3'b100);
    @(posedge clk); #1;

    // Fetch resumes cleanly after the abandoned store
    for (int n = 0; n < 30; n++)
      do_instr(ops[$urandom_range(0, 9)], $urandom_range(0, 2), $urandom_range(0, 2), len);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
